// File: rtl/snn_inference_ctrl.sv
// snn_inference_ctrl: sequences one inference of the spiking classifier.
//   Accepts an 8-bit frame, holds the network in clear for SETTLE_P cycles,
//   enables WINDOW_P timesteps, latches the argmax digit and offers it over
//   a valid/ready handshake.
// Optional feature macro: SNN_CTRL_ABORT_EN (adds abort_i / aborted_o).
// Ports:
//   clk_i, rst_ni            clock, async active-low reset
//   in_valid_i/in_ready_o    frame handshake; frame_i input frame
//   frame_o                  captured frame during RUN, else 0
//   net_clr_o, net_en_o      datapath sync-clear and timestep-enable
//   step_o                   timestep index during RUN, else 0
//   digit_i                  predicted digit from max_spike
//   res_valid_o/res_ready_i  result handshake; res_digit_o latched digit
//   busy_o                   high outside IDLE
//   abort_i, aborted_o       (SNN_CTRL_ABORT_EN only) abort request / 1-cycle pulse
module snn_inference_ctrl #(
   parameter int unsigned WINDOW_P = 64,
   parameter int unsigned SETTLE_P = 2,
   parameter int unsigned STEP_W   = $clog2(WINDOW_P + 1)
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [7:0]        frame_i,
   output logic [7:0]        frame_o,
   output logic              net_clr_o,
   output logic              net_en_o,
   output logic [STEP_W-1:0] step_o,
   input  logic [3:0]        digit_i,
   output logic              res_valid_o,
   input  logic              res_ready_i,
   output logic [3:0]        res_digit_o,
   output logic              busy_o
`ifdef SNN_CTRL_ABORT_EN
   ,
   input  logic              abort_i,
   output logic              aborted_o
`endif
);

   localparam int unsigned SET_W = $clog2(SETTLE_P + 1);
   localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(WINDOW_P - 1);
   localparam logic [SET_W-1:0]  SET_INIT  = SET_W'(SETTLE_P - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_RUN,
      ST_LATCH,
      ST_RESULT
   } state_e;

   state_e              state_q, state_d;
   logic [7:0]          frame_q, frame_d;
   logic [7:0]          frame_out_q, frame_out_d;
   logic                clr_q, clr_d;
   logic                en_q, en_d;
   logic [STEP_W-1:0]   step_q, step_d;
   logic [SET_W-1:0]    settle_q, settle_d;
   logic                res_valid_q, res_valid_d;
   logic [3:0]          res_digit_q, res_digit_d;
   logic                busy_q, busy_d;
`ifdef SNN_CTRL_ABORT_EN
   logic                aborted_q, aborted_d;
`endif

   // Next-state and next-output logic; every output is computed one edge
   // ahead so that it is registered in the state it belongs to.
   always_comb begin
      state_d     = state_q;
      frame_d     = frame_q;
      settle_d    = settle_q;
      step_d      = step_q;
      res_digit_d = res_digit_q;
      clr_d       = 1'b0;
      en_d        = 1'b0;
      frame_out_d = 8'h00;
      res_valid_d = 1'b0;
`ifdef SNN_CTRL_ABORT_EN
      aborted_d   = 1'b0;
`endif

      unique case (state_q)
         ST_IDLE: begin
            if (in_valid_i) begin
               frame_d  = frame_i;
               settle_d = SET_INIT;
               clr_d    = 1'b1;
               state_d  = ST_CLEAR;
            end
         end
         ST_CLEAR: begin
            // settle_q counts the remaining clear cycles after this one
            if (settle_q == '0) begin
               step_d      = '0;
               en_d        = 1'b1;
               frame_out_d = frame_q;
               state_d     = ST_RUN;
            end else begin
               settle_d = settle_q - SET_W'(1);
               clr_d    = 1'b1;
            end
         end
         ST_RUN: begin
            if (step_q == STEP_LAST) begin
               step_d  = '0;
               state_d = ST_LATCH;
            end else begin
               step_d      = step_q + STEP_W'(1);
               en_d        = 1'b1;
               frame_out_d = frame_q;
            end
         end
         ST_LATCH: begin
            // counters are frozen this cycle, so digit_i is final
            res_digit_d = digit_i;
            res_valid_d = 1'b1;
            state_d     = ST_RESULT;
         end
         ST_RESULT: begin
            if (res_ready_i) begin
               state_d = ST_IDLE;
            end else begin
               res_valid_d = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

`ifdef SNN_CTRL_ABORT_EN
      // Abort overrides every active state; the last result digit is kept.
      if (abort_i && (state_q != ST_IDLE)) begin
         state_d     = ST_IDLE;
         clr_d       = 1'b0;
         en_d        = 1'b0;
         frame_out_d = 8'h00;
         step_d      = '0;
         settle_d    = '0;
         res_valid_d = 1'b0;
         res_digit_d = res_digit_q;
         aborted_d   = 1'b1;
      end
`endif

      busy_d = (state_d != ST_IDLE);
   end

   // State and output registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= ST_IDLE;
         frame_q     <= 8'h00;
         frame_out_q <= 8'h00;
         clr_q       <= 1'b0;
         en_q        <= 1'b0;
         step_q      <= '0;
         settle_q    <= '0;
         res_valid_q <= 1'b0;
         res_digit_q <= 4'h0;
         busy_q      <= 1'b0;
`ifdef SNN_CTRL_ABORT_EN
         aborted_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         frame_q     <= frame_d;
         frame_out_q <= frame_out_d;
         clr_q       <= clr_d;
         en_q        <= en_d;
         step_q      <= step_d;
         settle_q    <= settle_d;
         res_valid_q <= res_valid_d;
         res_digit_q <= res_digit_d;
         busy_q      <= busy_d;
`ifdef SNN_CTRL_ABORT_EN
         aborted_q   <= aborted_d;
`endif
      end
   end

   // Ready is a plain state decode so it is already 1 during reset.
   assign in_ready_o  = (state_q == ST_IDLE);
   assign frame_o     = frame_out_q;
   assign net_clr_o   = clr_q;
   assign net_en_o    = en_q;
   assign step_o      = step_q;
   assign res_valid_o = res_valid_q;
   assign res_digit_o = res_digit_q;
   assign busy_o      = busy_q;
`ifdef SNN_CTRL_ABORT_EN
   assign aborted_o   = aborted_q;
`endif

endmodule

// File: tb/tb_snn_inference_ctrl.sv
// Testbench for snn_inference_ctrl (WINDOW_P=4, SETTLE_P=2).
// Stimulus pushes the expected result digit on acceptance; a negedge
// monitor pops and compares on every result handshake.
module tb_snn_inference_ctrl;

   localparam int unsigned W  = 4;
   localparam int unsigned S  = 2;
   localparam int unsigned SW = 3;

   logic          clk = 1'b0;
   logic          rst_ni = 1'b1;
   logic          in_valid_i = 1'b0;
   logic          in_ready_o;
   logic [7:0]    frame_i = 8'h00;
   logic [7:0]    frame_o;
   logic          net_clr_o;
   logic          net_en_o;
   logic [SW-1:0] step_o;
   logic [3:0]    digit_i = 4'h0;
   logic          res_valid_o;
   logic          res_ready_i = 1'b0;
   logic [3:0]    res_digit_o;
   logic          busy_o;
`ifdef SNN_CTRL_ABORT_EN
   logic          abort_i = 1'b0;
   logic          aborted_o;
`endif

   int         checks   = 0;
   int         failures = 0;
   logic [3:0] exp_q[$];
   logic [3:0] mon_exp;
   logic       prev_v = 1'b0;
   logic       prev_r = 1'b0;
   logic [3:0] prev_d = 4'h0;

   snn_inference_ctrl #(.WINDOW_P(W), .SETTLE_P(S)) dut (
      .clk_i       (clk),
      .rst_ni      (rst_ni),
      .in_valid_i  (in_valid_i),
      .in_ready_o  (in_ready_o),
      .frame_i     (frame_i),
      .frame_o     (frame_o),
      .net_clr_o   (net_clr_o),
      .net_en_o    (net_en_o),
      .step_o      (step_o),
      .digit_i     (digit_i),
      .res_valid_o (res_valid_o),
      .res_ready_i (res_ready_i),
      .res_digit_o (res_digit_o),
      .busy_o      (busy_o)
`ifdef SNN_CTRL_ABORT_EN
      ,
      .abort_i     (abort_i),
      .aborted_o   (aborted_o)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_ready"}, 32'(in_ready_o), 32'd1);
      chk({tag, "_busy"},  32'(busy_o), 32'd0);
      chk({tag, "_clr"},   32'(net_clr_o), 32'd0);
      chk({tag, "_en"},    32'(net_en_o), 32'd0);
      chk({tag, "_frame"}, 32'(frame_o), 32'd0);
      chk({tag, "_step"},  32'(step_o), 32'd0);
      chk({tag, "_valid"}, 32'(res_valid_o), 32'd0);
   endtask

   // Accepts one frame and walks CLEAR/RUN/LATCH, ending in the first RESULT cycle.
   // With noisy set, digit_i wanders during RUN and after LATCH.
   task automatic run_frame(input logic [7:0] fr, input logic [3:0] dig, input bit noisy);
      frame_i    = fr;
      in_valid_i = 1'b1;
      digit_i    = noisy ? 4'd9 : dig;
      chk("accept_ready", 32'(in_ready_o), 32'd1);
      cyc();
      in_valid_i = 1'b0;
      frame_i    = 8'h00;
      exp_q.push_back(dig);
      for (int i = 0; i < int'(S); i++) begin
         chk("clear_clr",   32'(net_clr_o), 32'd1);
         chk("clear_en",    32'(net_en_o), 32'd0);
         chk("clear_busy",  32'(busy_o), 32'd1);
         chk("clear_ready", 32'(in_ready_o), 32'd0);
         chk("clear_frame", 32'(frame_o), 32'd0);
         cyc();
      end
      for (int s = 0; s < int'(W); s++) begin
         if (noisy) digit_i = 4'(1 + 2 * s);
         chk("run_en",    32'(net_en_o), 32'd1);
         chk("run_clr",   32'(net_clr_o), 32'd0);
         chk("run_frame", 32'(frame_o), 32'(fr));
         chk("run_step",  32'(step_o), 32'(s));
         chk("run_valid", 32'(res_valid_o), 32'd0);
         cyc();
      end
      digit_i = dig;
      chk("latch_en",    32'(net_en_o), 32'd0);
      chk("latch_clr",   32'(net_clr_o), 32'd0);
      chk("latch_frame", 32'(frame_o), 32'd0);
      chk("latch_step",  32'(step_o), 32'd0);
      chk("latch_valid", 32'(res_valid_o), 32'd0);
      chk("latch_busy",  32'(busy_o), 32'd1);
      cyc();
      chk("result_valid", 32'(res_valid_o), 32'd1);
      chk("result_ready", 32'(in_ready_o), 32'd0);
      if (noisy) digit_i = 4'd2;
   endtask

   // Result monitor: scoreboard pop, hold stability and clr/en exclusion.
   always @(negedge clk) begin
      if (!rst_ni) begin
         prev_v <= 1'b0;
         prev_r <= 1'b0;
         prev_d <= 4'h0;
      end else begin
         chk("clr_en_exclusive", 32'(net_clr_o & net_en_o), 32'd0);
         if (prev_v && !prev_r) begin
            chk("hold_valid_stable", 32'(res_valid_o), 32'd1);
            chk("hold_digit_stable", 32'(res_digit_o), 32'(prev_d));
         end
         if (res_valid_o && res_ready_i) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_result: got digit %0d, required no result at %0t",
                        res_digit_o, $time);
            end else begin
               mon_exp = exp_q.pop_front();
               chk("result_digit", 32'(res_digit_o), 32'(mon_exp));
            end
         end
         prev_v <= res_valid_o;
         prev_r <= res_ready_i;
         prev_d <= res_digit_o;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, required finish before 200000");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      rst_ni = 1'b0;
      cyc();
      chk_idle("reset");
      chk("reset_digit", 32'(res_digit_o), 32'd0);
      cyc();
      rst_ni = 1'b1;
      repeat (3) begin
         cyc();
         chk("post_reset_ready", 32'(in_ready_o), 32'd1);
         chk("post_reset_busy",  32'(busy_o), 32'd0);
      end

      // Basic run, consumer always ready
      res_ready_i = 1'b1;
      run_frame(8'hA5, 4'd7, 1'b0);
      chk("result_digit_a5", 32'(res_digit_o), 32'd7);
      cyc();
      chk_idle("after_a5");

      // Consumer stalls while a new frame is offered
      res_ready_i = 1'b0;
      run_frame(8'h11, 4'd2, 1'b0);
      in_valid_i = 1'b1;
      frame_i    = 8'h3C;
      repeat (5) begin
         chk("stall_ready", 32'(in_ready_o), 32'd0);
         chk("stall_valid", 32'(res_valid_o), 32'd1);
         chk("stall_digit", 32'(res_digit_o), 32'd2);
         cyc();
      end
      res_ready_i = 1'b1;
      cyc();
      chk("post_hs_ready", 32'(in_ready_o), 32'd1);
      chk("post_hs_busy",  32'(busy_o), 32'd0);
      chk("post_hs_valid", 32'(res_valid_o), 32'd0);
      run_frame(8'h3C, 4'd9, 1'b0);
      cyc();
      chk_idle("after_3c");

      // digit_i moves during RUN; only the LATCH value counts
      run_frame(8'h5A, 4'd4, 1'b1);
      chk("latched_not_live", 32'(res_digit_o), 32'd4);
      cyc();

      // Out-of-range digit passes through
      run_frame(8'hC3, 4'd15, 1'b0);
      cyc();
      chk_idle("after_c3");

      // Reset mid-RUN aborts with no result
      frame_i    = 8'h77;
      in_valid_i = 1'b1;
      cyc();
      in_valid_i = 1'b0;
      repeat (S) cyc();
      cyc();
      cyc();
      chk("pre_reset_step", 32'(step_o), 32'd2);
      chk("pre_reset_en",   32'(net_en_o), 32'd1);
      rst_ni = 1'b0;
      #1;
      chk_idle("async_reset");
      cyc();
      rst_ni = 1'b1;
      repeat (S + W + 4) begin
         cyc();
         chk("no_result_after_reset", 32'(res_valid_o), 32'd0);
      end

`ifdef SNN_CTRL_ABORT_EN
      // Abort at step 1, then a clean run
      frame_i    = 8'h42;
      in_valid_i = 1'b1;
      cyc();
      in_valid_i = 1'b0;
      repeat (S) cyc();
      cyc();
      chk("pre_abort_step", 32'(step_o), 32'd1);
      abort_i = 1'b1;
      cyc();
      abort_i = 1'b0;
      chk("abort_pulse", 32'(aborted_o), 32'd1);
      chk_idle("abort");
      cyc();
      chk("abort_pulse_end", 32'(aborted_o), 32'd0);
      repeat (S + W + 3) begin
         cyc();
         chk("no_result_after_abort", 32'(res_valid_o), 32'd0);
      end
      run_frame(8'h42, 4'd3, 1'b0);
      cyc();
      chk_idle("after_abort_run");
`endif

      repeat (2) cyc();
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
